fp_status_gen: RTL and testbench

Status-flag producer for the floating-point multiplier datapath. It takes operand classes and the pre-rounding exponent/rounding information of each product and emits the 8-bit status byte {2'b0, inexact, huge, tiny, nan, inf, zero}. The byte is consistent by construction with the status-bit mutual-exclusion checks. The block sits between the multiplier's normalize/round stage and the result consumer as a 2-stage valid/ready pipeline, with an optional sticky flag accumulator.

---
 rtl/fp_status_pkg.sv | 21 ++
 rtl/fp_status_classify.sv | 53 +++++
 rtl/fp_status_gen.sv | 85 ++++++++
 tb/tb_fp_status_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_status_pkg.sv
// Shared types and constants for the FP multiplier status-flag generator.
package fp_status_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ZERO   = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    localparam int ZERO_B    = 0;
    localparam int INF_B     = 1;
    localparam int NAN_B     = 2;
    localparam int TINY_B    = 3;
    localparam int HUGE_B    = 4;
    localparam int INEXACT_B = 5;

    localparam int EXP_W   = 10;
    localparam int EXP_MAX = 255;

endpackage

// File: rtl/fp_status_classify.sv
// Combinational priority decode from operand classes and rounding info
// to the status byte {2'b0, inexact, huge, tiny, nan, inf, zero}.
module fp_status_classify
    import fp_status_pkg::*;
(
    input  logic [1:0]       a_class,
    input  logic [1:0]       b_class,
    input  logic [EXP_W-1:0] exp_sum,
    input  logic             round_lost,
    input  logic             round_carry,
    output logic [7:0]       status
);

    fp_class_e a_c;
    fp_class_e b_c;
    logic signed [EXP_W:0] e;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_c = fp_class_e'(a_class);
    assign b_c = fp_class_e'(b_class);

    assign a_zero = (a_c == ZERO);
    assign b_zero = (b_c == ZERO);
    assign a_inf  = (a_c == INF);
    assign b_inf  = (b_c == INF);
    assign a_nan  = (a_c == NAN);
    assign b_nan  = (b_c == NAN);

    // One extra bit keeps exp_sum + carry from wrapping at the top of range.
    assign e = $signed({exp_sum[EXP_W-1], exp_sum}) + $signed({{EXP_W{1'b0}}, round_carry});

    always_comb begin
        status = 8'h00;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            status[NAN_B] = 1'b1;
        end else if (a_inf || b_inf) begin
            status[INF_B] = 1'b1;
        end else if (a_zero || b_zero) begin
            status[ZERO_B] = 1'b1;
        end else if (e >= (EXP_W+1)'(EXP_MAX)) begin
            status[HUGE_B]    = 1'b1;
            status[INF_B]     = 1'b1;
            status[INEXACT_B] = 1'b1;
        end else if (e <= 11'sd0) begin
            status[TINY_B]    = 1'b1;
            status[ZERO_B]    = 1'b1;
            status[INEXACT_B] = 1'b1;
        end else begin
            status[INEXACT_B] = round_lost;
        end
    end

endmodule

// File: rtl/fp_status_gen.sv
// Two-stage valid/ready status-flag pipeline with optional sticky accumulator.
// Define FP_STATUS_STICKY_EN to build the sticky register.
module fp_status_gen
    import fp_status_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a_class,
    input  logic [1:0]       b_class,
    input  logic [EXP_W-1:0] exp_sum,
    input  logic             round_lost,
    input  logic             round_carry,
    output logic [7:0]       status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sticky_status,
    input  logic             sticky_clr
);

    logic [7:0] cls_status;
    logic [7:0] s1_status;
    logic       s1_valid;
    logic       s2_load;
    logic       in_fire;

    fp_status_classify u_classify (
        .a_class     (a_class),
        .b_class     (b_class),
        .exp_sum     (exp_sum),
        .round_lost  (round_lost),
        .round_carry (round_carry),
        .status      (cls_status)
    );

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_status <= 8'h00;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_fire) begin
                s1_status <= cls_status;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            status    <= 8'h00;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                status <= s1_status;
            end
        end
    end

`ifdef FP_STATUS_STICKY_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    // A clear in the same cycle as a handshake keeps only the new beat's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_status <= 8'h00;
        end else if (out_fire) begin
            sticky_status <= (sticky_clr ? 8'h00 : sticky_status) | status;
        end else if (sticky_clr) begin
            sticky_status <= 8'h00;
        end
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_status     = 8'h00;
`endif

endmodule

// File: tb/tb_fp_status_gen.sv
// Directed self-checking bench for fp_status_gen.
module tb_fp_status_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] a_class = 2'd0;
    logic [1:0] b_class = 2'd0;
    logic [9:0] exp_sum = 10'd0;
    logic       round_lost = 1'b0;
    logic       round_carry = 1'b0;
    logic [7:0] status;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sticky_status;
    logic       sticky_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_status_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_class       (a_class),
        .b_class       (b_class),
        .exp_sum       (exp_sum),
        .round_lost    (round_lost),
        .round_carry   (round_carry),
        .status        (status),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sticky_status (sticky_status),
        .sticky_clr    (sticky_clr)
    );

    localparam int NV = 17;
    localparam logic [1:0] V_A   [NV] = '{0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 2, 0};
    localparam logic [1:0] V_B   [NV] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 3, 0};
    localparam logic [9:0] V_E   [NV] = '{10'd100, 10'd0, 10'd0, 10'd0, 10'd254, 10'h3FD, 10'd1,
                                          10'd254, 10'd0, 10'h3FF, 10'd50, 10'd0, 10'h1FF, 10'h200,
                                          10'd0, 10'd0, 10'd253};
    localparam logic       V_L   [NV] = '{1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0};
    localparam logic       V_C   [NV] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    localparam logic [7:0] V_EXP [NV] = '{8'h20, 8'h04, 8'h04, 8'h02, 8'h32, 8'h29, 8'h00,
                                          8'h20, 8'h29, 8'h29, 8'h01, 8'h02, 8'h32, 8'h29,
                                          8'h01, 8'h04, 8'h00};

    task automatic drive_beat(input logic [1:0] a, input logic [1:0] b, input logic [9:0] e,
                              input logic l, input logic c);
        a_class     = a;
        b_class     = b;
        exp_sum     = e;
        round_lost  = l;
        round_carry = c;
        in_valid    = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || status !== 8'h00 || in_ready !== 1'b1 || sticky_status !== 8'h00) begin
            failures++;
            $display("FAIL reset_during: out_valid=%b status=%h in_ready=%b sticky=%h expected 0/00/1/00",
                     out_valid, status, in_ready, sticky_status);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || status !== 8'h00 || in_ready !== 1'b1 || sticky_status !== 8'h00) begin
            failures++;
            $display("FAIL reset_after: out_valid=%b status=%h in_ready=%b sticky=%h expected 0/00/1/00",
                     out_valid, status, in_ready, sticky_status);
        end
    endtask

    task automatic test_classify();
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_beat(V_A[i], V_B[i], V_E[i], V_L[i], V_C[i]);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_early vec %0d: out_valid=%b expected 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || status !== V_EXP[i]) begin
                failures++;
                $display("FAIL classify vec %0d: out_valid=%b status=%h expected 1/%h",
                         i, out_valid, status, V_EXP[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [3] = '{8'h01, 8'h02, 8'h20};
        int in_idx = 0;
        int out_idx = 0;
        int stall_accepts = 0;
        logic acc, emit;
        logic [7:0] seen;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            case (in_idx)
                0: drive_beat(2'd1, 2'd0, 10'd7, 1'b0, 1'b0);
                1: drive_beat(2'd2, 2'd0, 10'd7, 1'b0, 1'b0);
                2: drive_beat(2'd0, 2'd0, 10'd100, 1'b1, 1'b0);
                default: in_valid = 1'b0;
            endcase
            #1;
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            seen = status;
            if (cyc >= 2 && cyc < 4) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || status !== 8'h01) begin
                    failures++;
                    $display("FAIL stall_hold cyc %0d: in_ready=%b out_valid=%b status=%h expected 0/1/01",
                             cyc, in_ready, out_valid, status);
                end
            end
            @(posedge clk);
            if (acc) begin
                in_idx++;
                if (cyc < 4) stall_accepts++;
            end
            if (emit) begin
                checks++;
                if (out_idx >= 3) begin
                    failures++;
                    $display("FAIL b2b_extra: status=%h emitted after all 3 beats", seen);
                end else if (seen !== exp_q[out_idx]) begin
                    failures++;
                    $display("FAIL b2b_order beat %0d: status=%h expected %h", out_idx, seen, exp_q[out_idx]);
                end
                out_idx++;
            end
        end
        checks++;
        if (stall_accepts != 2 || out_idx != 3) begin
            failures++;
            $display("FAIL b2b_counts: stall_accepts=%0d emitted=%0d expected 2/3", stall_accepts, out_idx);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_sticky();
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
`ifdef FP_STATUS_STICKY_EN
        checks++;
        if (sticky_status !== 8'h00) begin
            failures++;
            $display("FAIL sticky_clear: sticky=%h expected 00", sticky_status);
        end
        drive_beat(2'd0, 2'd0, 10'd100, 1'b1, 1'b0);
        @(negedge clk);
        drive_beat(2'd3, 2'd0, 10'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sticky_status !== 8'h24) begin
            failures++;
            $display("FAIL sticky_accum: sticky=%h expected 24", sticky_status);
        end
        drive_beat(2'd1, 2'd0, 10'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        checks++;
        if (sticky_status !== 8'h01) begin
            failures++;
            $display("FAIL sticky_clr_with_beat: sticky=%h expected 01", sticky_status);
        end
`else
        drive_beat(2'd0, 2'd0, 10'd300, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sticky_status !== 8'h00) begin
            failures++;
            $display("FAIL sticky_disabled: sticky=%h expected 00", sticky_status);
        end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        @(negedge clk);
        drive_beat(2'd2, 2'd1, 10'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive_beat(2'd0, 2'd0, 10'd300, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || status !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_midflight: out_valid=%b status=%h in_ready=%b expected 0/00/1",
                     out_valid, status, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_stale cyc %0d: out_valid=%b status=%h expected no beat", i, out_valid, status);
            end
        end
    endtask

    task automatic test_exclusion_sweep();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a_class     = 2'($urandom_range(0, 3));
            b_class     = 2'($urandom_range(0, 3));
            exp_sum     = 10'($urandom);
            round_lost  = 1'($urandom);
            round_carry = 1'($urandom);
            in_valid    = 1'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid) begin
                checks++;
                if (status[7:6] !== 2'b00 ||
                    (status[0] && status[1]) || (status[0] && status[2]) || (status[0] && status[4]) ||
                    (status[1] && status[3]) || (status[2] && status[3]) || (status[4] && status[3])) begin
                    failures++;
                    $display("FAIL exclusion cyc %0d: status=%h has a forbidden bit pair", i, status);
                end
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_classify();
        test_back_to_back();
        test_sticky();
        test_reset_midflight();
        test_exclusion_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
